kairo_busresp: RTL
==================

KAIRO_BUSRESP -- requirements
Module: kairo_busresp

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h4000_0000: byte base address of the responder window.
REQ-002 SHALL have parameter AW, default 6: word-index width; window size is 4*2^AW bytes.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2: wait states inserted before READY (0..15).
REQ-004 SHALL have port CLK, input, 1: single clock, rising edge.
REQ-005 SHALL have port RST_N, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port S_VALID, input, 1: request valid, held by the initiator until S_READY.
REQ-007 SHALL have port S_READY, output, 1: one-cycle transfer-complete pulse.
REQ-008 SHALL have port S_WSTB, input, 4: byte-lane write strobes; 4'b0000 means read.
REQ-009 SHALL have port S_ADDR, input, 32: byte address.
REQ-010 SHALL have port S_WDATA, input, 32: write data.
REQ-011 SHALL have port S_RDATA, output, 32: read data, valid only while S_READY=1.
REQ-012 SHALL have port S_EXCEPT, output, 1: error flag, valid only while S_READY=1.

Function
REQ-013 SHALL implement FSM IDLE, WAIT, RESP; IDLE->WAIT on S_VALID when WAIT_CYCLES>0, IDLE->RESP on S_VALID when WAIT_CYCLES=0, WAIT->RESP when the wait counter reaches 0, RESP->IDLE always.
REQ-014 SHALL latch S_WSTB, S_ADDR and S_WDATA in the cycle IDLE accepts S_VALID.
REQ-015 SHALL load the wait counter with WAIT_CYCLES-1 on IDLE->WAIT and decrement it by 1 per WAIT cycle.
REQ-016 SHALL drive S_READY=1 only in RESP, for exactly one cycle; completion latency from accept = 1+WAIT_CYCLES cycles.
REQ-017 SHALL hold S_READY=0 in IDLE even when S_VALID=1; after RESP, the next request is accepted no earlier than the cycle after RESP.
REQ-018 SHALL flag an error when the latched address lies outside [BASE_ADDR, BASE_ADDR+4*2^AW-1] or latched ADDR[1:0]!=0.
REQ-019 SHALL, on error, drive S_EXCEPT=1 and S_RDATA=0 in RESP and modify no storage.
REQ-020 SHALL, on a valid write, update only the byte lanes whose S_WSTB bit is 1 at the rising edge that ends RESP.
REQ-021 SHALL, on a valid read, drive S_RDATA with the addressed word and S_EXCEPT=0 in RESP.
REQ-022 SHALL, when S_VALID drops in WAIT (protocol violation), return to IDLE next cycle with no write and no S_READY pulse.
REQ-023 SHALL drive S_RDATA=0 and S_EXCEPT=0 outside RESP.
REQ-024 SHALL compute word index as (ADDR-BASE_ADDR)>>2, truncated to AW bits after the range check.

Reset
REQ-025 SHALL, with RST_N=0 at a rising edge, force state IDLE, wait counter 0, S_READY=0, S_RDATA=0, S_EXCEPT=0.
REQ-026 SHALL clear all storage words to 32'h0 on reset.
REQ-027 SHALL, on reset during WAIT or RESP, abandon the transfer with no write commit.

Configuration
REQ-028 SHALL, with KAIRO_BUSRESP_WAIT_EN defined, implement WAIT state and counter per REQ-013..REQ-016.
REQ-029 SHALL, without KAIRO_BUSRESP_WAIT_EN, omit WAIT state and counter, ignore WAIT_CYCLES, and always go IDLE->RESP (latency 1 cycle).

Structure
REQ-030 SHALL take FSM state encodings and bus width constants (WSTB 4, ADDR/DATA 32) from shared package kairo_bus_pkg.
REQ-031 SHALL place byte-lane storage in sub-module kairo_busresp_ram (one write port with 4 lane enables, one async read port).

Verification
REQ-032 SHALL cover: reset, write ADDR=32'h4000_0010 WDATA=32'hDEADBEEF WSTB=4'hF, then read same -> S_READY 3 cycles after each accept (WAIT_CYCLES=2, macro on), S_RDATA=32'hDEADBEEF, S_EXCEPT=0.
REQ-033 SHALL cover: over 32'h4000_0010=32'hDEADBEEF write WSTB=4'b0101 WDATA=32'h11223344 -> read returns 32'hDE22BE44.
REQ-034 SHALL cover: read ADDR=32'h4000_0100 (out of range) and ADDR=32'h4000_0002 (misaligned) -> S_READY with S_EXCEPT=1, S_RDATA=0; prior contents unchanged.
REQ-035 SHALL cover: drop S_VALID in first WAIT cycle of a write to 32'h4000_0020 -> no S_READY, later read returns 32'h0.
REQ-036 SHALL cover: assert RST_N=0 during RESP of a write -> S_READY=0 next cycle, storage all 32'h0.
REQ-037 SHALL cover: macro off, back-to-back reads with S_VALID held -> S_READY every second cycle, latency 1.

Source files
------------

// File: rtl/kairo_bus_pkg.sv
// Shared bus constants and responder FSM encodings for the kairo bus family.
// Ports: none (package only).
// Imported by kairo_busresp and kairo_busresp_ram.
package kairo_bus_pkg;

  localparam int WSTB_W = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/kairo_busresp_ram.sv
// Byte-lane word storage for the bus responder; contents clear on reset.
// Ports: CLK/RST_N; write port (we, be, waddr, wdata) commits on the rising edge;
// asynchronous read port (raddr -> rdata).
module kairo_busresp_ram
  import kairo_bus_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              we,
  input  logic [WSTB_W-1:0] be,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int b = 0; b < WSTB_W; b++) begin
        if (be[b]) begin
          mem_d[waddr][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/kairo_busresp.sv
// Single-window bus responder: accepts one request at a time, optionally inserts
// WAIT_CYCLES wait states, then pulses S_READY for one cycle with read data / error.
// Ports: CLK, RST_N (sync, active-low); S_VALID/S_READY handshake; S_WSTB, S_ADDR,
// S_WDATA request; S_RDATA, S_EXCEPT response. Wait states exist only when the
// macro KAIRO_BUSRESP_WAIT_EN is defined; otherwise every transfer takes 1 cycle.
module kairo_busresp
  import kairo_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h4000_0000,
  parameter int                AW          = 6,
  parameter int                WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [WSTB_W-1:0] S_WSTB,
  input  logic [ADDR_W-1:0] S_ADDR,
  input  logic [DATA_W-1:0] S_WDATA,
  output logic [DATA_W-1:0] S_RDATA,
  output logic              S_EXCEPT
);

  // The wait counter is 4 bits wide.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("kairo_busresp: WAIT_CYCLES must be in 0..15");
  end

  state_e            state_q, state_d;
  logic [WSTB_W-1:0] wstb_q, wstb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

`ifdef KAIRO_BUSRESP_WAIT_EN
  localparam bit HAS_WAIT = (WAIT_CYCLES != 0);
  logic [3:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    wstb_d  = wstb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef KAIRO_BUSRESP_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (S_VALID) begin
          wstb_d  = S_WSTB;
          addr_d  = S_ADDR;
          wdata_d = S_WDATA;
`ifdef KAIRO_BUSRESP_WAIT_EN
          if (HAS_WAIT) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = ST_RESP;
          end
`else
          state_d = ST_RESP;
`endif
        end
      end
      ST_WAIT: begin
`ifdef KAIRO_BUSRESP_WAIT_EN
        // Initiator withdrew the request: drop it silently.
        if (!S_VALID) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      wstb_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef KAIRO_BUSRESP_WAIT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      wstb_q  <= wstb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef KAIRO_BUSRESP_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Offset is computed one bit wider so an address below BASE_ADDR goes
  // negative and fails the same "upper bits zero" test as one above the window.
  logic [ADDR_W:0]   off;
  logic              in_range;
  logic              err;
  logic              resp;
  logic              ram_we;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] ram_rdata;

  assign off      = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign in_range = ((off >> (AW + 2)) == '0);
  assign err      = !in_range || (addr_q[1:0] != 2'b00);
  assign idx      = off[AW+1:2];
  assign resp     = (state_q == ST_RESP);
  // Commit happens on the edge that ends RESP; RAM reset has priority over it.
  assign ram_we   = resp && !err && (wstb_q != '0);

  kairo_busresp_ram #(
    .AW(AW)
  ) u_ram (
    .CLK  (CLK),
    .RST_N(RST_N),
    .we   (ram_we),
    .be   (wstb_q),
    .waddr(idx),
    .wdata(wdata_q),
    .raddr(idx),
    .rdata(ram_rdata)
  );

  assign S_READY  = resp;
  assign S_EXCEPT = resp && err;
  assign S_RDATA  = (resp && !err && (wstb_q == '0)) ? ram_rdata : '0;

endmodule
